traffic_phase_timer: RTL and testbench

Parametrised two-road intersection phase sequencer and countdown timer. It replaces the fixed per-road timers with a single block that owns the full phase cycle: main green, main yellow, all-red, side green, side yellow, all-red. Side-road demand is latched, main green has a minimum time, and side green is extended while traffic persists. It drives the light decoders and the countdown displays directly.

---
 rtl/traffic_phase_timer.sv | 170 +++++++++++++++++
 tb/tb_traffic_phase_timer.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_phase_timer.sv
// Two-road intersection phase sequencer with tick prescaler and countdown.
// Ports: clk, rst_n, sensor, hold in; phase, remain, phase_done, lights out.
`timescale 1ns/1ps
module traffic_phase_timer #(
  parameter int unsigned TICK_DIV = 11,
  parameter int unsigned CW       = 7,
  parameter int unsigned T_MG     = 59,
  parameter int unsigned T_Y      = 9,
  parameter int unsigned T_AR     = 1,
  parameter int unsigned T_SG     = 29,
  parameter int unsigned T_EXT    = 5,
  parameter int unsigned T_SGMAX  = 59
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          sensor,
  input  logic          hold,
  output logic [2:0]    phase,
  output logic [CW-1:0] remain,
  output logic          phase_done,
  output logic [2:0]    main_light,
  output logic [2:0]    side_light
);

  typedef enum logic [2:0] {
    MG  = 3'd0,
    MY  = 3'd1,
    AR1 = 3'd2,
    SG  = 3'd3,
    SY  = 3'd4,
    AR2 = 3'd5
  } phase_e;

  localparam int unsigned PW =
    (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
  localparam logic [CW-1:0] LD_MG    = CW'(T_MG);
  localparam logic [CW-1:0] LD_Y     = CW'(T_Y);
  localparam logic [CW-1:0] LD_AR    = CW'(T_AR);
  localparam logic [CW-1:0] LD_SG    = CW'(T_SG);
  localparam logic [CW-1:0] LD_EXT   = CW'(T_EXT);
  localparam logic [CW:0]   SGMAX    = (CW+1)'(T_SGMAX);
  localparam logic [CW:0]   USED_MAX = '1;

  logic [PW-1:0] pre_q, pre_d;
  phase_e        phase_q, phase_d;
  logic [CW-1:0] remain_q, remain_d;
  logic          done_q, done_d;
  logic          demand_q, demand_d;
  logic [CW:0]   used_q, used_d;
  logic [2:0]    main_q, main_d;
  logic [2:0]    side_q, side_d;
  logic          tick;

  assign tick = (pre_q == PRE_LAST) && !hold;

  always_comb begin
    pre_d    = pre_q;
    phase_d  = phase_q;
    remain_d = remain_q;
    done_d   = 1'b0;
    demand_d = demand_q;
    used_d   = used_q;

    if (!hold)
      pre_d = (pre_q == PRE_LAST) ? '0 : pre_q + 1'b1;

    if (sensor && phase_q != SG)
      demand_d = 1'b1;

    if (phase_q > AR2) begin
      // unreachable encodings recover without waiting for a tick
      phase_d  = MG;
      remain_d = LD_MG;
      done_d   = 1'b1;
    end else if (tick) begin
      if (phase_q == SG && used_q != USED_MAX)
        used_d = used_q + 1'b1;
      if (remain_q != '0) begin
        remain_d = remain_q - 1'b1;
      end else begin
        case (phase_q)
          MG: begin
            // wait at zero until side demand
            if (demand_q) begin
              phase_d  = MY;
              remain_d = LD_Y;
              done_d   = 1'b1;
            end
          end
          MY: begin
            phase_d  = AR1;
            remain_d = LD_AR;
            done_d   = 1'b1;
          end
          AR1: begin
            // clear beats a same-edge sensor set
            phase_d  = SG;
            remain_d = LD_SG;
            done_d   = 1'b1;
            demand_d = 1'b0;
            used_d   = '0;
          end
          SG: begin
            if (sensor && used_q < SGMAX) begin
              remain_d = LD_EXT;
            end else begin
              phase_d  = SY;
              remain_d = LD_Y;
              done_d   = 1'b1;
            end
          end
          SY: begin
            phase_d  = AR2;
            remain_d = LD_AR;
            done_d   = 1'b1;
          end
          AR2: begin
            phase_d  = MG;
            remain_d = LD_MG;
            done_d   = 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    main_d = 3'b100;
    side_d = 3'b100;
    case (phase_d)
      MG:      main_d = 3'b001;
      MY:      main_d = 3'b010;
      SG:      side_d = 3'b001;
      SY:      side_d = 3'b010;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q    <= '0;
      phase_q  <= MG;
      remain_q <= LD_MG;
      done_q   <= 1'b0;
      demand_q <= 1'b0;
      used_q   <= '0;
      main_q   <= 3'b001;
      side_q   <= 3'b100;
    end else begin
      pre_q    <= pre_d;
      phase_q  <= phase_d;
      remain_q <= remain_d;
      done_q   <= done_d;
      demand_q <= demand_d;
      used_q   <= used_d;
      main_q   <= main_d;
      side_q   <= side_d;
    end
  end

  assign phase      = phase_q;
  assign remain     = remain_q;
  assign phase_done = done_q;
  assign main_light = main_q;
  assign side_light = side_q;

endmodule

// File: tb/tb_traffic_phase_timer.sv
// Bench for traffic_phase_timer: directed timing scenarios plus
// random sensor/hold traffic against a tick-level reference model.
`timescale 1ns/1ps
module tb_traffic_phase_timer;

  typedef struct {
    int div; int cw; int mg; int y;
    int ar;  int sg; int ext; int sgmax;
  } cfg_t;

  typedef struct {
    int pre; int ph; int rem; int used;
    bit dem; bit done;
  } m_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sensor = 1'b0;
  logic       hold = 1'b0;

  logic [2:0] phase;
  logic [6:0] remain;
  logic       phase_done;
  logic [2:0] main_light;
  logic [2:0] side_light;

  logic [2:0] f_phase;
  logic [3:0] f_remain;
  logic       f_done;
  logic [2:0] f_main;
  logic [2:0] f_side;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  cfg_t c0 = '{11, 7, 59, 9, 1, 29, 5, 59};
  cfg_t c1 = '{1, 4, 5, 2, 1, 3, 1, 7};
  m_t   m0, m1;

  int main_tab[6] = '{1, 2, 4, 4, 4, 4};
  int side_tab[6] = '{4, 4, 4, 1, 2, 4};

  always #5 clk = ~clk;

  traffic_phase_timer u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sensor     (sensor),
    .hold       (hold),
    .phase      (phase),
    .remain     (remain),
    .phase_done (phase_done),
    .main_light (main_light),
    .side_light (side_light)
  );

  traffic_phase_timer #(
    .TICK_DIV(1), .CW(4), .T_MG(5), .T_Y(2),
    .T_AR(1), .T_SG(3), .T_EXT(1), .T_SGMAX(7)
  ) u_fast (
    .clk        (clk),
    .rst_n      (rst_n),
    .sensor     (sensor),
    .hold       (hold),
    .phase      (f_phase),
    .remain     (f_remain),
    .phase_done (f_done),
    .main_light (f_main),
    .side_light (f_side)
  );

  function automatic int load_of(cfg_t c, int ph);
    case (ph)
      0: return c.mg;
      1: return c.y;
      2: return c.ar;
      3: return c.sg;
      4: return c.y;
      default: return c.ar;
    endcase
  endfunction

  function automatic m_t m_reset(cfg_t c);
    m_t s;
    s.pre = 0; s.ph = 0; s.rem = c.mg;
    s.used = 0; s.dem = 0; s.done = 0;
    return s;
  endfunction

  // One clock edge of the intersection, seen as tick arithmetic.
  function automatic m_t m_step(m_t s, cfg_t c, bit sn, bit hd);
    m_t n = s;
    bit tk = (s.pre == c.div - 1) && !hd;
    bit stay;
    int sat = (1 << (c.cw + 1)) - 1;
    n.done = 0;
    if (!hd) n.pre = (s.pre + 1) % c.div;
    if (sn && s.ph != 3) n.dem = 1;
    if (tk) begin
      if (s.ph == 3) n.used = (s.used + 1 > sat) ? sat : s.used + 1;
      if (s.rem > 0) begin
        n.rem = s.rem - 1;
      end else begin
        stay = (s.ph == 0 && !s.dem) ||
               (s.ph == 3 && sn && s.used < c.sgmax);
        if (stay) begin
          if (s.ph == 3) n.rem = c.ext;
        end else begin
          n.ph = (s.ph + 1) % 6;
          n.rem = load_of(c, n.ph);
          n.done = 1;
          if (n.ph == 3) begin
            n.dem = 0;
            n.used = 0;
          end
        end
      end
    end
    return n;
  endfunction

  task automatic cycle();
    @(posedge clk);
    m0 = m_step(m0, c0, sensor, hold);
    m1 = m_step(m1, c1, sensor, hold);
    cyc++;
    #1;
  endtask

  task automatic run_to(int n);
    while (cyc < n) cycle();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    sensor = 1'b0;
    hold = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    m0 = m_reset(c0);
    m1 = m_reset(c1);
    cyc = 0;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if (phase !== 3'd0) begin
      bad++; $display("FAIL rst_phase got=%0d exp=0", phase);
    end
    total++;
    if (remain !== 7'd59) begin
      bad++; $display("FAIL rst_remain got=%0d exp=59", remain);
    end
    total++;
    if (phase_done !== 1'b0) begin
      bad++; $display("FAIL rst_done got=%b exp=0", phase_done);
    end
    total++;
    if (main_light !== 3'b001 || side_light !== 3'b100) begin
      bad++;
      $display("FAIL rst_lights got=%b/%b exp=001/100",
               main_light, side_light);
    end
    total++;
    if (f_remain !== 4'd5) begin
      bad++; $display("FAIL rst_fast_remain got=%0d exp=5", f_remain);
    end
  endtask

  task automatic test_idle();
    do_reset();
    while (cyc < 700) begin
      cycle();
      total++;
      if (phase !== 3'd0 || phase_done !== 1'b0) begin
        bad++;
        $display("FAIL idle_phase cyc=%0d got=%0d/%b exp=0/0",
                 cyc, phase, phase_done);
      end
      if (cyc == 10 || cyc == 11 || cyc == 648 || cyc == 649) begin
        int e;
        e = (cyc == 10) ? 59 : (cyc == 11) ? 58 :
            (cyc == 648) ? 1 : 0;
        total++;
        if (remain !== 7'(e)) begin
          bad++;
          $display("FAIL idle_remain cyc=%0d got=%0d exp=%0d",
                   cyc, remain, e);
        end
      end
    end
    total++;
    if (remain !== 7'd0) begin
      bad++; $display("FAIL idle_hold0 got=%0d exp=0", remain);
    end
  endtask

  task automatic test_single_and_sustained();
    int pulses;
    do_reset();
    run_to(99);
    sensor = 1'b1;
    cycle();
    sensor = 1'b0;
    run_to(659);
    total++;
    if (phase !== 3'd0) begin
      bad++; $display("FAIL single_pre got=%0d exp=0", phase);
    end
    cycle();
    total++;
    if (phase !== 3'd1 || remain !== 7'd9 || phase_done !== 1'b1) begin
      bad++;
      $display("FAIL single_my got=%0d/%0d/%b exp=1/9/1",
               phase, remain, phase_done);
    end
    cycle();
    total++;
    if (phase_done !== 1'b0) begin
      bad++; $display("FAIL single_pulse got=%b exp=0", phase_done);
    end
    run_to(770);
    total++;
    if (phase !== 3'd2 || remain !== 7'd1) begin
      bad++;
      $display("FAIL single_ar1 got=%0d/%0d exp=2/1", phase, remain);
    end
    run_to(792);
    total++;
    if (phase !== 3'd3 || remain !== 7'd29 || side_light !== 3'b001 ||
        main_light !== 3'b100) begin
      bad++;
      $display("FAIL single_sg got=%0d/%0d/%b/%b exp=3/29/100/001",
               phase, remain, main_light, side_light);
    end
    sensor = 1'b1;
    pulses = 0;
    while (cyc < 1451) begin
      cycle();
      if (phase_done) pulses++;
    end
    total++;
    if (phase !== 3'd3 || pulses != 0) begin
      bad++;
      $display("FAIL sust_sg got=%0d/%0d exp=3/0", phase, pulses);
    end
    cycle();
    total++;
    if (phase !== 3'd4 || remain !== 7'd9 || phase_done !== 1'b1) begin
      bad++;
      $display("FAIL sust_sy got=%0d/%0d/%b exp=4/9/1",
               phase, remain, phase_done);
    end
    sensor = 1'b0;
  endtask

  task automatic test_hold();
    do_reset();
    run_to(99);
    sensor = 1'b1;
    cycle();
    sensor = 1'b0;
    run_to(299);
    hold = 1'b1;
    run_to(349);
    hold = 1'b0;
    total++;
    if (remain !== 7'd32) begin
      bad++; $display("FAIL hold_frozen got=%0d exp=32", remain);
    end
    run_to(709);
    total++;
    if (phase !== 3'd0) begin
      bad++; $display("FAIL hold_pre got=%0d exp=0", phase);
    end
    cycle();
    total++;
    if (phase !== 3'd1 || phase_done !== 1'b1) begin
      bad++;
      $display("FAIL hold_my got=%0d/%b exp=1/1", phase, phase_done);
    end
  endtask

  task automatic test_demand_sy();
    do_reset();
    run_to(99);
    sensor = 1'b1;
    cycle();
    sensor = 1'b0;
    run_to(1122);
    total++;
    if (phase !== 3'd4) begin
      bad++; $display("FAIL dsy_sy got=%0d exp=4", phase);
    end
    run_to(1149);
    sensor = 1'b1;
    cycle();
    sensor = 1'b0;
    run_to(1254);
    total++;
    if (phase !== 3'd0 || remain !== 7'd59) begin
      bad++;
      $display("FAIL dsy_mg got=%0d/%0d exp=0/59", phase, remain);
    end
    run_to(1913);
    total++;
    if (phase !== 3'd0) begin
      bad++; $display("FAIL dsy_full got=%0d exp=0", phase);
    end
    cycle();
    total++;
    if (phase !== 3'd1) begin
      bad++; $display("FAIL dsy_my got=%0d exp=1", phase);
    end
  endtask

  task automatic test_reset_sg();
    do_reset();
    run_to(99);
    sensor = 1'b1;
    cycle();
    run_to(1150);
    total++;
    if (phase !== 3'd3) begin
      bad++; $display("FAIL rsg_in_sg got=%0d exp=3", phase);
    end
    #3;
    rst_n = 1'b0;
    #1;
    total++;
    if (phase !== 3'd0 || remain !== 7'd59 || phase_done !== 1'b0 ||
        main_light !== 3'b001 || side_light !== 3'b100) begin
      bad++;
      $display("FAIL rsg_async got=%0d/%0d/%b/%b/%b exp=0/59/0/001/100",
               phase, remain, phase_done, main_light, side_light);
    end
    do_reset();
    run_to(10);
    total++;
    if (remain !== 7'd59) begin
      bad++; $display("FAIL rsg_restart10 got=%0d exp=59", remain);
    end
    cycle();
    total++;
    if (remain !== 7'd58) begin
      bad++; $display("FAIL rsg_restart11 got=%0d exp=58", remain);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 6000; i++) begin
      sensor = ($urandom_range(0, 99) < 8);
      hold = ($urandom_range(0, 99) < 3);
      cycle();
      total++;
      if (phase !== 3'(m0.ph) || remain !== 7'(m0.rem) ||
          phase_done !== m0.done ||
          main_light !== 3'(main_tab[m0.ph]) ||
          side_light !== 3'(side_tab[m0.ph])) begin
        bad++;
        $display("FAIL rand_def cyc=%0d got=%0d/%0d/%b exp=%0d/%0d/%b",
                 cyc, phase, remain, phase_done, m0.ph, m0.rem, m0.done);
      end
      total++;
      if (f_phase !== 3'(m1.ph) || f_remain !== 4'(m1.rem) ||
          f_done !== m1.done ||
          f_main !== 3'(main_tab[m1.ph]) ||
          f_side !== 3'(side_tab[m1.ph])) begin
        bad++;
        $display("FAIL rand_fast cyc=%0d got=%0d/%0d/%b exp=%0d/%0d/%b",
                 cyc, f_phase, f_remain, f_done, m1.ph, m1.rem, m1.done);
      end
    end
    sensor = 1'b0;
    hold = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    m0 = m_reset(c0);
    m1 = m_reset(c1);
    test_reset();
    test_idle();
    test_single_and_sustained();
    test_hold();
    test_demand_sy();
    test_reset_sg();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
